conway_board_ctrl: RTL and testbench
====================================

CONWAY_BOARD_CTRL -- requirements
Module: conway_board_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning board height (>=3).
REQ-002 SHALL have parameter COLS, default 8, meaning board width (>=3).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1, global enable; low freezes every register except reset.
REQ-006 SHALL have port load_valid, input, 1, writes load_data into board row load_row.
REQ-007 SHALL have port load_row, input, $clog2(ROWS), row index for load.
REQ-008 SHALL have port load_data, input, COLS, row contents; bit c is column c.
REQ-009 SHALL have ports step/run/stop, input, 1 each: single generation, continuous run, halt.
REQ-010 SHALL have port rd_row, input, $clog2(ROWS), readback row select.
REQ-011 SHALL have port rd_data, output, COLS, registered committed row rd_row.
REQ-012 SHALL have ports busy (1), gen_done (1), stable (1) and gen_count (16), all outputs.

Function
REQ-013 SHALL hold committed board (ROWS x COLS) and shadow next-board registers.
REQ-014 SHALL implement FSM IDLE, COMPUTE, COMMIT; busy = state != IDLE.
REQ-015 SHALL, in IDLE, priority stop > step > run: stop keeps IDLE; step or run enters COMPUTE, and run sets run_mode.
REQ-016 SHALL, in COMPUTE, evaluate row r in the r-th COMPUTE cycle (r = 0..ROWS-1) using COLS Game-of-Life rule evaluators reading only the committed board, writing the shadow row r.
REQ-017 SHALL apply rule: dead cell with exactly 3 live neighbours born; live cell with 2 or 3 survives; all else dead.
REQ-018 SHALL enter COMMIT after row ROWS-1; COMMIT copies shadow to board, increments gen_count modulo 2^16 (0xFFFF -> 0x0000), pulses gen_done one cycle after COMMIT.
REQ-019 SHALL set stable=1 at COMMIT when shadow equals board, else 0; stable holds until next COMMIT or load.
REQ-020 SHALL, from COMMIT, return to COMPUTE if run_mode=1, else IDLE; generation period ROWS+1 cycles.
REQ-021 SHALL latch stop while busy: clears run_mode; current generation completes and commits, then IDLE.
REQ-022 SHALL ignore step/run while busy and ignore load_valid unless state=IDLE; load clears stable.
REQ-023 SHALL, when load_valid and step assert together in IDLE, perform the load and defer step (step ignored).
REQ-024 SHALL update rd_data one cycle after rd_row with board contents as of that edge (post-commit value in COMMIT cycle+1).
REQ-025 SHALL, with ena=0, freeze FSM, row counter, board, shadow, gen_count; gen_done forced 0.

Reset
REQ-026 SHALL, on rst=0 asynchronously: state IDLE, board and shadow all 0, run_mode 0, gen_count 0, gen_done 0, stable 0, rd_data 0, busy 0.
REQ-027 SHALL, when reset asserts mid-COMPUTE or COMMIT, discard the generation in progress; no partial commit.

Configuration
REQ-028 SHALL honour macro CONWAY_TORUS_EN: defined -> edges wrap (row -1 = ROWS-1, column -1 = COLS-1, and vice versa); undefined -> cells outside board are dead.

Verification
REQ-029 SHALL cover: 8x8, load vertical blinker (rows 2..4, col 3), step -> after 9 cycles row 3 = 8'b0001_1100, gen_count=1, gen_done pulsed once.
REQ-030 SHALL cover: 2x2 block at rows 1..2 cols 1..2, step -> board unchanged, stable=1.
REQ-031 SHALL cover: glider, run for 32 generations with CONWAY_TORUS_EN -> glider returns to original position, gen_count=32; without macro -> glider becomes a still-life block at the corner after collision.
REQ-032 SHALL cover: run, then stop mid-COMPUTE (row 4) -> that generation commits, busy falls after COMMIT, gen_count increments exactly once more.
REQ-033 SHALL cover: load_valid during COMPUTE -> board unaffected; rst=0 during row 5 of COMPUTE -> all outputs 0 immediately.
REQ-034 SHALL cover: gen_count preset to 0xFFFF by 65535 run generations (or forced) -> next COMMIT yields 0x0000.

Source files
------------

// File: rtl/conway_board_ctrl.sv
// Game-of-Life board controller: evaluates one row per cycle into a shadow board, then commits.
// Define CONWAY_TORUS_EN to make the board edges wrap; otherwise cells off the board are dead.
module conway_board_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    load_valid,
  input  logic [$clog2(ROWS)-1:0] load_row,
  input  logic [COLS-1:0]         load_data,
  input  logic                    step,
  input  logic                    run,
  input  logic                    stop,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data,
  output logic                    busy,
  output logic                    gen_done,
  output logic                    stable,
  output logic [15:0]             gen_count
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

  state_e                     state_q, state_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       run_mode_q, run_mode_d;
  logic [ROWS-1:0][COLS-1:0]  board_q, shadow_q;
  logic [15:0]                gen_count_q;
  logic                       gen_done_q, stable_q;
  logic [COLS-1:0]            rd_data_q;
  logic [COLS-1:0]            next_row;
  logic                       do_load;

  function automatic logic cell_at(input logic [ROWS-1:0][COLS-1:0] b, input int r, input int c);
`ifdef CONWAY_TORUS_EN
    int rw, cw;
    rw = (r + ROWS) % ROWS;
    cw = (c + COLS) % COLS;
    return b[RW'(rw)][CW'(cw)];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return b[RW'(r)][CW'(c)];
`endif
  endfunction

  function automatic logic [COLS-1:0] eval_row(input logic [ROWS-1:0][COLS-1:0] b, input int r);
    logic [COLS-1:0] res;
    int n;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) n += int'(cell_at(b, r + dr, c + dc));
        end
      end
      res[CW'(c)] = (n == 3) || (n == 2 && b[RW'(r)][CW'(c)]);
    end
    return res;
  endfunction

  always_comb next_row = eval_row(board_q, int'(row_q));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    run_mode_d = run_mode_q;
    do_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        do_load = load_valid;
        if (stop) begin
          run_mode_d = 1'b0;
        end else if (!load_valid && (step || run)) begin
          // A load in the same cycle wins; the start request is dropped.
          state_d    = StCompute;
          row_d      = '0;
          run_mode_d = run && !step;
        end
      end
      StCompute: begin
        if (stop) run_mode_d = 1'b0;
        if (row_q == RW'(ROWS - 1)) state_d = StCommit;
        else                        row_d   = row_q + 1'b1;
      end
      StCommit: begin
        row_d = '0;
        if (stop) run_mode_d = 1'b0;
        state_d = (run_mode_q && !stop) ? StCompute : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      run_mode_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      row_q      <= row_d;
      run_mode_q <= run_mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q     <= '0;
      shadow_q    <= '0;
      gen_count_q <= '0;
      gen_done_q  <= 1'b0;
      stable_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      gen_done_q <= ena && (state_q == StCommit);
      if (ena) begin
        rd_data_q <= board_q[rd_row];
        if (do_load) begin
          board_q[load_row] <= load_data;
          stable_q          <= 1'b0;
        end
        if (state_q == StCompute) shadow_q[row_q] <= next_row;
        if (state_q == StCommit) begin
          board_q     <= shadow_q;
          gen_count_q <= gen_count_q + 16'd1;
          stable_q    <= (shadow_q == board_q);
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q != StIdle);
  assign gen_done  = gen_done_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_conway_board_ctrl.sv
// Randomized bench for conway_board_ctrl against a whole-board Game-of-Life model.
module tb_conway_board_ctrl;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic            clk = 1'b0;
  logic            rst, ena, load_valid, step, run, stop;
  logic [2:0]      load_row, rd_row;
  logic [7:0]      load_data, rd_data;
  logic            busy, gen_done, stable;
  logic [15:0]     gen_count;

  int              checks = 0;
  int              errors = 0;
  logic [7:0]      mdl [ROWS];
  logic [7:0]      dut_rows [ROWS];
  logic            mdl_stable;
  logic [15:0]     exp_count;

  conway_board_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .load_valid (load_valid),
    .load_row   (load_row),
    .load_data  (load_data),
    .step       (step),
    .run        (run),
    .stop       (stop),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .busy       (busy),
    .gen_done   (gen_done),
    .stable     (stable),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_board();
    for (int r = 0; r < ROWS; r++) begin
      load_valid = 1'b1;
      load_row   = 3'(r);
      load_data  = mdl[r];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic read_board();
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 3'(r);
      tick();
      dut_rows[r] = rd_data;
    end
  endtask

  task automatic random_model();
    for (int r = 0; r < ROWS; r++) mdl[r] = 8'($urandom);
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++) mdl[r] = 8'h00;
  endtask

  // One generation computed directly from the birth/survival rule over the whole board.
  task automatic model_step();
    logic [7:0] nx [ROWS];
    int n, rr, cc;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef CONWAY_TORUS_EN
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
`endif
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) n += int'(mdl[rr][cc]);
            end
          end
        end
        nx[r][c] = mdl[r][c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    mdl_stable = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (nx[r] !== mdl[r]) mdl_stable = 1'b0;
      mdl[r] = nx[r];
    end
  endtask

  task automatic wait_idle(input int budget, output int cycles, output int pulses, output bit ok);
    cycles = 0;
    pulses = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (gen_done === 1'b1) pulses++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL reset_gen_done: got %b want 0", gen_done); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b want 0", stable); end
    checks++; if (gen_count !== 16'h0) begin errors++; $display("FAIL reset_gen_count: got %h want 0", gen_count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rst = 1'b1;
    tick();
    exp_count = 16'h0;
    clear_model();
  endtask

  task automatic test_blinker();
    bit busy_bad = 1'b0;
    int pulses = 0;
    clear_model();
    mdl[2] = 8'h08; mdl[3] = 8'h08; mdl[4] = 8'h08;
    push_board();
    model_step();
    exp_count++;
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (gen_done === 1'b1) pulses++;
      if (i < 9 && busy !== 1'b1) busy_bad = 1'b1;
    end
    checks++; if (busy_bad) begin errors++; $display("FAIL blinker_busy_during: busy dropped early, want high for 8 cycles"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blinker_busy_end: got %b want 0", busy); end
    checks++; if (gen_done !== 1'b1) begin errors++; $display("FAIL blinker_gen_done: got %b want 1", gen_done); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL blinker_count: got %h want %h", gen_count, exp_count); end
    tick();
    if (gen_done === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL blinker_pulses: got %0d want 1", pulses); end
    read_board();
    checks++; if (dut_rows[3] !== 8'b0001_1100) begin errors++; $display("FAIL blinker_row3: got %b want 00011100", dut_rows[3]); end
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL blinker_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
  endtask

  task automatic test_block();
    int cyc, pul;
    bit ok;
    clear_model();
    mdl[1] = 8'h06; mdl[2] = 8'h06;
    push_board();
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL block_load_clears: got %b want 0", stable); end
    model_step();
    exp_count++;
    step = 1'b1; tick(); step = 1'b0;
    wait_idle(30, cyc, pul, ok);
    checks++; if (!ok) begin errors++; $display("FAIL block_timeout: busy still %b after %0d cycles", busy, cyc); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL block_stable: got %b want 1", stable); end
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL block_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
  endtask

  task automatic test_load_and_step();
    logic [7:0] d;
    d = 8'($urandom);
    load_valid = 1'b1; load_row = 3'd5; load_data = d; step = 1'b1;
    tick();
    load_valid = 1'b0; step = 1'b0;
    mdl[5] = d;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_step_busy: got %b want 0", busy); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL load_step_stable: got %b want 0", stable); end
    rd_row = 3'd5; tick();
    checks++; if (rd_data !== d) begin errors++; $display("FAIL load_step_row5: got %h want %h", rd_data, d); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL load_step_count: got %h want %h", gen_count, exp_count); end
  endtask

  task automatic test_busy_ignore();
    int cyc, pul;
    bit ok;
    random_model();
    push_board();
    model_step();
    exp_count++;
    step = 1'b1; tick(); step = 1'b0;
    repeat (2) tick();
    load_valid = 1'b1; load_row = 3'($urandom); load_data = 8'($urandom);
    run = 1'b1; step = 1'b1;
    repeat (2) tick();
    load_valid = 1'b0; run = 1'b0; step = 1'b0;
    wait_idle(30, cyc, pul, ok);
    checks++; if (!ok || cyc != 5) begin errors++; $display("FAIL busy_ignore_len: got %0d cycles want 5", cyc); end
    repeat (10) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_run: got busy %b want 0", busy); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL busy_ignore_count: got %h want %h", gen_count, exp_count); end
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL busy_ignore_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
  endtask

  task automatic test_enable();
    int cyc, pul;
    bit ok;
    bit frz_bad = 1'b0;
    random_model();
    push_board();
    model_step();
    step = 1'b1; tick(); step = 1'b0;
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) begin
      tick();
      if (busy !== 1'b1 || gen_done !== 1'b0 || gen_count !== exp_count) frz_bad = 1'b1;
    end
    ena = 1'b1;
    exp_count++;
    wait_idle(30, cyc, pul, ok);
    checks++; if (frz_bad) begin errors++; $display("FAIL enable_freeze: state moved while ena low, busy %b count %h", busy, gen_count); end
    checks++; if (!ok || cyc != 6) begin errors++; $display("FAIL enable_resume: got %0d cycles want 6", cyc); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL enable_count: got %h want %h", gen_count, exp_count); end
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL enable_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
  endtask

  task automatic test_stop_mid();
    int cyc, pul;
    bit ok;
    random_model();
    push_board();
    model_step();
    exp_count++;
    run = 1'b1; tick(); run = 1'b0;
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(30, cyc, pul, ok);
    checks++; if (!ok || cyc != 4) begin errors++; $display("FAIL stop_mid_len: got %0d cycles want 4", cyc); end
    checks++; if (pul != 1) begin errors++; $display("FAIL stop_mid_pulses: got %0d want 1", pul); end
    repeat (10) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_mid_idle: got busy %b want 0", busy); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL stop_mid_count: got %h want %h", gen_count, exp_count); end
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL stop_mid_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
  endtask

  task automatic test_glider();
    logic [7:0] orig [ROWS];
    int pulses = 0;
    int last = -1;
    int cyc = 0;
    bit period_bad = 1'b0;
    clear_model();
    mdl[0] = 8'b0000_0010; mdl[1] = 8'b0000_0100; mdl[2] = 8'b0000_0111;
    for (int r = 0; r < ROWS; r++) orig[r] = mdl[r];
    push_board();
    for (int g = 0; g < 32; g++) model_step();
    exp_count += 16'd32;
    run = 1'b1; tick(); run = 1'b0;
    while (busy === 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      stop = 1'b0;
      if (gen_done === 1'b1) begin
        pulses++;
        if (last >= 0 && cyc - last != ROWS + 1) period_bad = 1'b1;
        last = cyc;
        if (pulses == 31) stop = 1'b1;
      end
    end
    stop = 1'b0;
    checks++; if (pulses != 32) begin errors++; $display("FAIL glider_gens: got %0d want 32", pulses); end
    checks++; if (period_bad) begin errors++; $display("FAIL glider_period: generation spacing differs from %0d", ROWS + 1); end
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL glider_count: got %h want %h", gen_count, exp_count); end
    checks++; if (stable !== mdl_stable) begin errors++; $display("FAIL glider_stable: got %b want %b", stable, mdl_stable); end
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL glider_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
`ifdef CONWAY_TORUS_EN
      checks++; if (dut_rows[r] !== orig[r]) begin errors++; $display("FAIL glider_home%0d: got %b want %b", r, dut_rows[r], orig[r]); end
`endif
    end
  endtask

  task automatic test_random();
    int cyc, pul;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      random_model();
      push_board();
      model_step();
      exp_count++;
      step = 1'b1; tick(); step = 1'b0;
      wait_idle(30, cyc, pul, ok);
      checks++; if (!ok || pul != 1) begin errors++; $display("FAIL random%0d_done: ok %b pulses %0d want 1", it, ok, pul); end
      checks++; if (stable !== mdl_stable) begin errors++; $display("FAIL random%0d_stable: got %b want %b", it, stable, mdl_stable); end
      checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL random%0d_count: got %h want %h", it, gen_count, exp_count); end
      read_board();
      for (int r = 0; r < ROWS; r++) begin
        checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL random%0d_row%0d: got %b want %b", it, r, dut_rows[r], mdl[r]); end
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, pul;
    bit ok;
    force dut.gen_count_q = 16'hFFFF;
    #1;
    release dut.gen_count_q;
    #1;
    checks++; if (gen_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffff", gen_count); end
    model_step();
    step = 1'b1; tick(); step = 1'b0;
    wait_idle(30, cyc, pul, ok);
    exp_count = 16'hFFFF + 16'd1;
    checks++; if (gen_count !== exp_count) begin errors++; $display("FAIL wrap_count: got %h want %h", gen_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    random_model();
    push_board();
    step = 1'b1; tick(); step = 1'b0;
    repeat (5) tick();
    load_valid = 1'b1; load_row = 3'd1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_gen_done: got %b want 0", gen_done); end
    checks++; if (stable !== 1'b0) begin errors++; $display("FAIL rst_mid_stable: got %b want 0", stable); end
    checks++; if (gen_count !== 16'h0) begin errors++; $display("FAIL rst_mid_count: got %h want 0", gen_count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rd_data: got %h want 0", rd_data); end
    rst = 1'b1;
    clear_model();
    read_board();
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (dut_rows[r] !== mdl[r]) begin errors++; $display("FAIL rst_mid_row%0d: got %b want %b", r, dut_rows[r], mdl[r]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_commit: busy %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; load_valid = 1'b0; load_row = '0; load_data = '0;
    step = 1'b0; run = 1'b0; stop = 1'b0; rd_row = '0;
    exp_count = 16'h0;
    test_reset();
    test_blinker();
    test_block();
    test_load_and_step();
    test_busy_ignore();
    test_enable();
    test_stop_mid();
    test_glider();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
